bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 26 ++
 rtl/bus_arbiter_rr_pick.sv | 30 +++
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the snoop-bus arbiter.
package bus_arbiter_pkg;

  localparam int MAX_CORES = 8;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  function automatic logic [MAX_CORES-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_CORES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner_i, wrapping.
module rr_pick #(
  parameter int NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [$clog2(NUM_CORES)-1:0] last_owner_i,
  output logic [$clog2(NUM_CORES)-1:0] winner_o,
  output logic                         valid_o
);

  localparam int IDW = $clog2(NUM_CORES);

  // Scan from last_owner+1 so the previous owner is considered last.
  always_comb begin
    logic [IDW-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = IDW'((int'(last_owner_i) + i) % NUM_CORES);
      if (!valid_o && req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snoop-bus arbiter with round-robin ownership and snoop hit/flush combining.
// Optional hold-time preemption is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              req_core,
  output logic [NUM_CORES-1:0]              grant,
  input  logic [NUM_CORES-1:0][31:0]        core_data_in,
  input  logic [NUM_CORES-1:0][31:0]        core_address_in,
  input  logic [NUM_CORES-1:0][1:0]         core_operation_in,
  input  logic [NUM_CORES-1:0]              core_hit_in,
  input  logic [NUM_CORES-1:0]              core_flush_in,
  output logic [31:0]                       bus_data_out,
  output logic [31:0]                       bus_address_out,
  output logic [1:0]                        bus_operation_out,
  output logic                              bus_hit_out,
  output logic                              bus_flush_out,
  output logic [$clog2(NUM_CORES)-1:0]      owner_id
);

  localparam int IDW = $clog2(NUM_CORES);

  arb_state_t           state_q;
  logic [NUM_CORES-1:0] grant_q;
  logic [IDW-1:0]       owner_q;
  logic [IDW-1:0]       last_owner_q;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_valid;
  logic                 timeout;
  logic                 release_req;
  logic [NUM_CORES-1:0] snoop_flush;

  rr_pick #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_pick (
    .req_i        (req_core),
    .last_owner_i (last_owner_q),
    .winner_o     (pick_idx),
    .valid_o      (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_q;

  assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Count consecutive owned cycles; cleared whenever ownership ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (state_q == GRANT && !release_req) begin
      hold_q <= hold_q + 1'b1;
    end else begin
      hold_q <= '0;
    end
  end
`else
  localparam int unused_max_hold = MAX_HOLD;

  assign timeout = 1'b0;
`endif

  assign release_req = !req_core[owner_q] || timeout;
  assign snoop_flush = core_flush_in & ~grant_q;

  // Arbitration FSM; grant and owner are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDW'(NUM_CORES - 1);
    end else begin
      case (state_q)
        IDLE, RELEASE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            grant_q <= NUM_CORES'(idx_to_onehot(3'(pick_idx)));
            owner_q <= pick_idx;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        GRANT: begin
          if (release_req) begin
            state_q      <= RELEASE;
            grant_q      <= '0;
            last_owner_q <= owner_q;
          end else begin
            state_q <= GRANT;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Broadcast mux; a non-owner flush overrides the owner's data, lowest index first.
  always_comb begin
    bus_operation_out = BUS_NON;
    bus_address_out   = 32'h0000_0000;
    bus_data_out      = 32'h0000_0000;
    bus_hit_out       = 1'b0;
    bus_flush_out     = 1'b0;
    if (state_q == GRANT) begin
      bus_operation_out = core_operation_in[owner_q];
      bus_address_out   = core_address_in[owner_q];
      bus_data_out      = core_data_in[owner_q];
      bus_hit_out       = |(core_hit_in & ~grant_q);
      bus_flush_out     = |snoop_flush;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (snoop_flush[i]) begin
          bus_data_out = core_data_in[i];
        end else begin
          bus_data_out = bus_data_out;
        end
      end
    end else begin
      bus_operation_out = BUS_NON;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (two cores).
module tb_bus_arbiter;

  localparam int N        = 2;
  localparam int MAX_HOLD = 16;

  localparam int SEL_GRANT = 0;
  localparam int SEL_OP    = 1;
  localparam int SEL_DATA  = 2;
  localparam int SEL_ADDR  = 3;
  localparam int SEL_HIT   = 4;
  localparam int SEL_FLUSH = 5;
  localparam int SEL_OWNER = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic                clk;
  logic                reset;
  logic [N-1:0]        req_core;
  logic [N-1:0]        grant;
  logic [N-1:0][31:0]  core_data_in;
  logic [N-1:0][31:0]  core_address_in;
  logic [N-1:0][1:0]   core_operation_in;
  logic [N-1:0]        core_hit_in;
  logic [N-1:0]        core_flush_in;
  logic [31:0]         bus_data_out;
  logic [31:0]         bus_address_out;
  logic [1:0]          bus_operation_out;
  logic                bus_hit_out;
  logic                bus_flush_out;
  logic [$clog2(N)-1:0] owner_id;

  bus_arbiter #(
    .NUM_CORES (N),
    .MAX_HOLD  (MAX_HOLD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_core          (req_core),
    .grant             (grant),
    .core_data_in      (core_data_in),
    .core_address_in   (core_address_in),
    .core_operation_in (core_operation_in),
    .core_hit_in       (core_hit_in),
    .core_flush_in     (core_flush_in),
    .bus_data_out      (bus_data_out),
    .bus_address_out   (bus_address_out),
    .bus_operation_out (bus_operation_out),
    .bus_hit_out       (bus_hit_out),
    .bus_flush_out     (bus_flush_out),
    .owner_id          (owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_GRANT: return 32'(grant);
      SEL_OP:    return 32'(bus_operation_out);
      SEL_DATA:  return bus_data_out;
      SEL_ADDR:  return bus_address_out;
      SEL_HIT:   return 32'(bus_hit_out);
      SEL_FLUSH: return 32'(bus_flush_out);
      SEL_OWNER: return 32'(owner_id);
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_idle(input string tag);
    expect_val({tag, "_grant"}, SEL_GRANT, 32'd0);
    expect_val({tag, "_op"},    SEL_OP,    32'd3);
    expect_val({tag, "_data"},  SEL_DATA,  32'd0);
    expect_val({tag, "_addr"},  SEL_ADDR,  32'd0);
    expect_val({tag, "_hit"},   SEL_HIT,   32'd0);
    expect_val({tag, "_flush"}, SEL_FLUSH, 32'd0);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    check();
  endtask

  task automatic now_chk();
    #1;
    check();
  endtask

  initial begin
    reset             = 1'b0;
    req_core          = 2'b00;
    core_hit_in       = 2'b00;
    core_flush_in     = 2'b00;
    core_operation_in[0] = 2'b10;
    core_operation_in[1] = 2'b01;
    core_address_in[0]   = 32'h0000_1000;
    core_address_in[1]   = 32'h0000_2000;
    core_data_in[0]      = 32'h1111_0000;
    core_data_in[1]      = 32'h2222_0000;

    // Reset state
    #3;
    expect_idle("rst");
    expect_val("rst_owner", SEL_OWNER, 32'd0);
    now_chk();

    // Single requester: one-cycle latency, op follows owner
    @(posedge clk);
    #2;
    reset    = 1'b1;
    req_core = 2'b01;
    expect_val("g0_grant", SEL_GRANT, 32'h1);
    expect_val("g0_owner", SEL_OWNER, 32'd0);
    expect_val("g0_op",    SEL_OP,    32'd2);
    expect_val("g0_addr",  SEL_ADDR,  32'h0000_1000);
    expect_val("g0_data",  SEL_DATA,  32'h1111_0000);
    expect_val("g0_hit",   SEL_HIT,   32'd0);
    cyc();
    core_operation_in[0] = 2'b00;
    expect_val("g0_op_follow", SEL_OP, 32'd0);
    now_chk();
    req_core = 2'b00;
    expect_idle("g0_rel");
    cyc();
    expect_val("g0_idle", SEL_GRANT, 32'd0);
    cyc();

    // Snoop hit / flush combining
    req_core = 2'b01;
    expect_val("fl_grant", SEL_GRANT, 32'h1);
    cyc();
    core_hit_in     = 2'b10;
    core_flush_in   = 2'b10;
    core_data_in[1] = 32'hDEAD_BEEF;
    expect_val("fl_hit",   SEL_HIT,   32'd1);
    expect_val("fl_flush", SEL_FLUSH, 32'd1);
    expect_val("fl_data",  SEL_DATA,  32'hDEAD_BEEF);
    expect_val("fl_op",    SEL_OP,    32'd0);
    now_chk();
    core_hit_in   = 2'b01;
    core_flush_in = 2'b01;
    expect_val("own_hit",   SEL_HIT,   32'd0);
    expect_val("own_flush", SEL_FLUSH, 32'd0);
    expect_val("own_data",  SEL_DATA,  32'h1111_0000);
    now_chk();
    core_hit_in   = 2'b00;
    core_flush_in = 2'b00;
    req_core      = 2'b00;
    expect_idle("fl_rel");
    cyc();
    cyc();

    // Round-robin from reset with both cores requesting
    reset    = 1'b0;
    req_core = 2'b11;
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_val("rr_g0", SEL_GRANT, 32'h1);
      cyc();
    end
    req_core = 2'b10;
    expect_val("rr_gap1", SEL_GRANT, 32'd0);
    expect_val("rr_gap1_op", SEL_OP, 32'd3);
    cyc();
    expect_val("rr_g1_owner", SEL_OWNER, 32'd1);
    expect_val("rr_g1_op",    SEL_OP,    32'd1);
    expect_val("rr_g1_addr",  SEL_ADDR,  32'h0000_2000);
    for (int k = 0; k < 3; k++) begin
      expect_val("rr_g1", SEL_GRANT, 32'h2);
      cyc();
    end
    req_core = 2'b01;
    expect_val("rr_gap2", SEL_GRANT, 32'd0);
    cyc();
    expect_val("rr_g0_again", SEL_GRANT, 32'h1);
    cyc();
    req_core = 2'b00;
    expect_val("rr_gap3", SEL_GRANT, 32'd0);
    cyc();
    cyc();

    // last_owner is core0, so core1 wins a simultaneous request
    req_core = 2'b11;
    expect_val("rot_g1", SEL_GRANT, 32'h2);
    cyc();
    req_core = 2'b01;
    expect_val("rot_gap", SEL_GRANT, 32'd0);
    cyc();
    expect_val("rot_g0", SEL_GRANT, 32'h1);
    cyc();

    // Asynchronous reset mid-GRANT
    reset = 1'b0;
    expect_val("arst_grant", SEL_GRANT, 32'd0);
    expect_val("arst_op",    SEL_OP,    32'd3);
    now_chk();
    @(posedge clk);
    #2;
    reset    = 1'b1;
    req_core = 2'b10;
    expect_val("arst_g1",       SEL_GRANT, 32'h2);
    expect_val("arst_g1_owner", SEL_OWNER, 32'd1);
    cyc();
    req_core = 2'b00;
    cyc();
    cyc();

    // Long hold with a competing request
    reset    = 1'b0;
    req_core = 2'b11;
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < MAX_HOLD; k++) begin
      expect_val("hold_g0", SEL_GRANT, 32'h1);
      cyc();
    end
`ifdef ARB_TIMEOUT_EN
    expect_val("tmo_gap", SEL_GRANT, 32'd0);
    cyc();
    expect_val("tmo_g1", SEL_GRANT, 32'h2);
    cyc();
`else
    for (int k = 0; k < 4; k++) begin
      expect_val("hold_g0_ext", SEL_GRANT, 32'h1);
      cyc();
    end
    req_core = 2'b10;
    expect_val("hold_gap", SEL_GRANT, 32'd0);
    cyc();
    expect_val("hold_g1", SEL_GRANT, 32'h2);
    cyc();
`endif
    req_core = 2'b00;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
